// File: rtl/forward_unit.sv
// forward_unit: operand-forwarding selects and load-use stall detection for
// a five-stage-style pipeline. The block tracks every instruction it admits
// through shadow EX, MEM, WB and RET stages. It registers the EX operand mux
// selects one cycle ahead, so they are valid while the instruction sits in EX.
// Optional feature: define FWD_STALL_CNT_EN to add a saturating 16-bit
// load-use stall counter on port w_stall_cnt_16.
module forward_unit (
  input  logic       w_clk,
  input  logic       w_rst,
  input  logic       w_id_valid_1,
  input  logic [4:0] w_id_rs_5,
  input  logic [4:0] w_id_rt_5,
  input  logic [4:0] w_id_rd_5,
  input  logic       w_id_regwrite_1,
  input  logic       w_id_memread_1,
  output logic [1:0] w_fwd_a_2,
  output logic [1:0] w_fwd_b_2,
  output logic       w_stall_1
`ifdef FWD_STALL_CNT_EN
  ,
  output logic [15:0] w_stall_cnt_16
`endif
);

  // Shadow record of one in-flight instruction.
  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       regwrite;
    logic       memread;
  } stage_t;

  // The select names the place the producer will occupy on the next edge,
  // which is when the consumer reaches EX.
  typedef enum logic [1:0] {
    SEL_RF  = 2'b00,
    SEL_MEM = 2'b01,
    SEL_WB  = 2'b10,
    SEL_RET = 2'b11
  } fwd_sel_e;

  localparam int EX  = 0;
  localparam int MEM = 1;
  localparam int WB  = 2;
  localparam int NUM_STAGES = 4;  // EX, MEM, WB, RET

  stage_t   pipe [NUM_STAGES];
  stage_t   id_entry;
  fwd_sel_e sel_a_next;
  fwd_sel_e sel_b_next;
  fwd_sel_e fwd_a;
  fwd_sel_e fwd_b;
  logic     stall;

  // A stage supplies register r only if it really writes a non-zero r.
  function automatic logic stage_hit(input stage_t s, input logic [4:0] r);
    return s.valid && s.regwrite && (s.rd != 5'd0) && (s.rd == r);
  endfunction

  // Youngest producer wins: EX, then MEM, then WB.
  function automatic fwd_sel_e pick_sel(input stage_t ex_s, input stage_t mem_s,
                                        input stage_t wb_s, input logic [4:0] r);
    if (stage_hit(ex_s, r))       return SEL_MEM;
    else if (stage_hit(mem_s, r)) return SEL_WB;
    else if (stage_hit(wb_s, r))  return SEL_RET;
    else                          return SEL_RF;
  endfunction

  // Decode-side view: stall detection, next selects and the EX entry record.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    stall      = 1'b0;
    sel_a_next = SEL_RF;
    sel_b_next = SEL_RF;
    id_entry   = '0;

    stall = w_id_valid_1 && pipe[EX].valid && pipe[EX].memread &&
            (pipe[EX].rd != 5'd0) &&
            ((pipe[EX].rd == w_id_rs_5) || (pipe[EX].rd == w_id_rt_5));

    if (w_id_valid_1 && !stall) begin
      sel_a_next = pick_sel(pipe[EX], pipe[MEM], pipe[WB], w_id_rs_5);
      sel_b_next = pick_sel(pipe[EX], pipe[MEM], pipe[WB], w_id_rt_5);
    end

    // A stalled instruction is replaced by a bubble; it re-enters next cycle.
    if (!stall) begin
      id_entry.valid    = w_id_valid_1;
      id_entry.rd       = w_id_rd_5;
      id_entry.regwrite = w_id_regwrite_1;
      id_entry.memread  = w_id_memread_1;
    end
  end

  // Shadow pipeline advance and registered select update.
  always_ff @(posedge w_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every stage
    // shifts from its pre-edge neighbour regardless of statement order.
    if (w_rst) begin
      for (int i = 0; i < NUM_STAGES; i++) pipe[i] <= '0;
      fwd_a <= SEL_RF;
      fwd_b <= SEL_RF;
    end else begin
      pipe[EX] <= id_entry;
      for (int i = 1; i < NUM_STAGES; i++) pipe[i] <= pipe[i-1];
      fwd_a <= sel_a_next;
      fwd_b <= sel_b_next;
    end
  end

  assign w_fwd_a_2 = fwd_a;
  assign w_fwd_b_2 = fwd_b;
  assign w_stall_1 = stall;

`ifdef FWD_STALL_CNT_EN
  logic [15:0] stall_cnt;

  // Count load-use stall cycles, holding at all-ones instead of wrapping.
  always_ff @(posedge w_clk) begin
    if (w_rst)                              stall_cnt <= '0;
    else if (stall && (stall_cnt != 16'hFFFF)) stall_cnt <= stall_cnt + 16'd1;
  end

  assign w_stall_cnt_16 = stall_cnt;
`endif

endmodule

// File: tb/tb_forward_unit.sv
// tb_forward_unit: directed-vector bench for forward_unit. Inputs change
// one time unit after a rising edge; selects and stall are sampled there too.
module tb_forward_unit;

  logic       w_clk;
  logic       w_rst;
  logic       w_id_valid_1;
  logic [4:0] w_id_rs_5;
  logic [4:0] w_id_rt_5;
  logic [4:0] w_id_rd_5;
  logic       w_id_regwrite_1;
  logic       w_id_memread_1;
  logic [1:0] w_fwd_a_2;
  logic [1:0] w_fwd_b_2;
  logic       w_stall_1;
`ifdef FWD_STALL_CNT_EN
  logic [15:0] w_stall_cnt_16;
`endif

  int checks = 0;
  int errors = 0;

  forward_unit dut (
    .w_clk          (w_clk),
    .w_rst          (w_rst),
    .w_id_valid_1   (w_id_valid_1),
    .w_id_rs_5      (w_id_rs_5),
    .w_id_rt_5      (w_id_rt_5),
    .w_id_rd_5      (w_id_rd_5),
    .w_id_regwrite_1(w_id_regwrite_1),
    .w_id_memread_1 (w_id_memread_1),
    .w_fwd_a_2      (w_fwd_a_2),
    .w_fwd_b_2      (w_fwd_b_2),
    .w_stall_1      (w_stall_1)
`ifdef FWD_STALL_CNT_EN
    ,
    .w_stall_cnt_16 (w_stall_cnt_16)
`endif
  );

  initial w_clk = 1'b0;
  always #5 w_clk = ~w_clk;

  task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic rw, input logic mr);
    w_id_valid_1    = v;
    w_id_rs_5       = rs;
    w_id_rt_5       = rt;
    w_id_rd_5       = rd;
    w_id_regwrite_1 = rw;
    w_id_memread_1  = mr;
  endtask

  task automatic step();
    @(posedge w_clk);
    #1;
  endtask

  task automatic nop();
    set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
  endtask

  // Empties EX, MEM and WB so each scenario starts from a clean pipeline.
  task automatic flush();
    nop();
    repeat (3) step();
  endtask

  task automatic chk_sel(input string name, input logic [1:0] exp_a, input logic [1:0] exp_b);
    checks++;
    if (w_fwd_a_2 !== exp_a) begin
      errors++;
      $display("FAIL %s fwd_a got %b expected %b", name, w_fwd_a_2, exp_a);
    end
    checks++;
    if (w_fwd_b_2 !== exp_b) begin
      errors++;
      $display("FAIL %s fwd_b got %b expected %b", name, w_fwd_b_2, exp_b);
    end
  endtask

  task automatic chk_stall(input string name, input logic exp);
    checks++;
    if (w_stall_1 !== exp) begin
      errors++;
      $display("FAIL %s stall got %b expected %b", name, w_stall_1, exp);
    end
  endtask

`ifdef FWD_STALL_CNT_EN
  task automatic chk_cnt(input string name, input logic [15:0] exp);
    checks++;
    if (w_stall_cnt_16 !== exp) begin
      errors++;
      $display("FAIL %s cnt got %0d expected %0d", name, w_stall_cnt_16, exp);
    end
  endtask
`endif

  task automatic test_reset();
    #1;
    w_rst = 1'b1;
    repeat (2) begin
      set_id(1'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
             1'($urandom), 1'($urandom));
      step();
    end
    w_rst = 1'b0;
    set_id(1'b1, 5'd3, 5'd3, 5'd3, 1'b1, 1'b1);
    #1;
    chk_stall("reset", 1'b0);
    chk_sel("reset", 2'b00, 2'b00);
`ifdef FWD_STALL_CNT_EN
    chk_cnt("reset", 16'd0);
`endif
  endtask

  task automatic test_ex_forward();
    flush();
    set_id(1'b1, 5'd1, 5'd2, 5'd8, 1'b1, 1'b0);
    #1 chk_stall("ex_fwd_i1", 1'b0);
    step();
    chk_sel("ex_fwd_i1", 2'b00, 2'b00);
    set_id(1'b1, 5'd8, 5'd9, 5'd3, 1'b1, 1'b0);
    #1 chk_stall("ex_fwd_i2", 1'b0);
    step();
    chk_sel("ex_fwd_i2", 2'b01, 2'b00);
  endtask

  task automatic test_priority();
    flush();
    set_id(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0);
    step();
    set_id(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0);
    step();
    set_id(1'b1, 5'd5, 5'd5, 5'd6, 1'b1, 1'b0);
    step();
    chk_sel("priority", 2'b01, 2'b01);
  endtask

  task automatic test_load_use();
    flush();
    set_id(1'b1, 5'd0, 5'd0, 5'd10, 1'b1, 1'b1);
    step();
    set_id(1'b1, 5'd11, 5'd10, 5'd12, 1'b1, 1'b0);
    #1 chk_stall("load_use_hit", 1'b1);
    step();
    chk_stall("load_use_release", 1'b0);
    chk_sel("load_use_bubble", 2'b00, 2'b00);
    step();
    chk_sel("load_use_fwd", 2'b00, 2'b10);
`ifdef FWD_STALL_CNT_EN
    chk_cnt("load_use", 16'd1);
`endif
  endtask

  task automatic test_zero_gap();
    flush();
    set_id(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1);
    step();
    set_id(1'b1, 5'd0, 5'd0, 5'd2, 1'b1, 1'b0);
    #1 chk_stall("zero_reg", 1'b0);
    step();
    chk_sel("zero_reg", 2'b00, 2'b00);

    flush();
    set_id(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0);
    step();
    nop();
    repeat (2) step();
    set_id(1'b1, 5'd7, 5'd1, 5'd2, 1'b1, 1'b0);
    step();
    chk_sel("gap_ret", 2'b11, 2'b00);

    flush();
    set_id(1'b1, 5'd0, 5'd0, 5'd6, 1'b1, 1'b0);
    step();
    nop();
    step();
    set_id(1'b1, 5'd1, 5'd6, 5'd2, 1'b1, 1'b0);
    step();
    chk_sel("gap_wb", 2'b00, 2'b10);
  endtask

  task automatic test_back_to_back();
    flush();
    set_id(1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 1'b0);
    step();
    nop();
    repeat (2) step();
    set_id(1'b1, 5'd9, 5'd9, 5'd1, 1'b1, 1'b0);
    step();
    chk_sel("same_rs_rt", 2'b11, 2'b11);

    flush();
    set_id(1'b1, 5'd0, 5'd0, 5'd4, 1'b1, 1'b0);
    step();
    set_id(1'b0, 5'd4, 5'd4, 5'd1, 1'b1, 1'b0);
    step();
    chk_sel("invalid_id", 2'b00, 2'b00);

    flush();
    set_id(1'b1, 5'd0, 5'd0, 5'd4, 1'b0, 1'b0);
    step();
    set_id(1'b1, 5'd4, 5'd4, 5'd1, 1'b1, 1'b0);
    step();
    chk_sel("no_regwrite", 2'b00, 2'b00);
  endtask

  task automatic test_mid_stall_reset();
    flush();
    set_id(1'b1, 5'd0, 5'd0, 5'd10, 1'b1, 1'b1);
    step();
    set_id(1'b1, 5'd11, 5'd10, 5'd12, 1'b1, 1'b0);
    #1 chk_stall("mid_rst_before", 1'b1);
    w_rst = 1'b1;
    step();
    w_rst = 1'b0;
    #1;
    chk_stall("mid_rst_after", 1'b0);
    chk_sel("mid_rst_after", 2'b00, 2'b00);
`ifdef FWD_STALL_CNT_EN
    chk_cnt("mid_rst", 16'd0);
`endif
    step();
    chk_sel("mid_rst_held", 2'b00, 2'b00);
    set_id(1'b1, 5'd10, 5'd10, 5'd13, 1'b1, 1'b0);
    step();
    chk_sel("mid_rst_next", 2'b00, 2'b00);
  endtask

  initial begin
    w_rst = 1'b1;
    nop();
    test_reset();
    test_ex_forward();
    test_priority();
    test_load_use();
    test_zero_gap();
    test_back_to_back();
    test_mid_stall_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/forward_unit.md
FORWARD_UNIT -- requirements
Module: forward_unit

Interface
REQ-001 Parameter: none; register specifiers are fixed at 5 bits and forward selects at 2 bits.
REQ-002 w_clk  in  1  single clock; all state updates on the rising edge.
REQ-003 w_rst  in  1  reset, synchronous, active-high.
REQ-004 w_id_valid_1  in  1  decode-stage instruction valid.
REQ-005 w_id_rs_5 / w_id_rt_5  in  5 each  source register specifiers of the decode-stage instruction.
REQ-006 w_id_rd_5  in  5  destination register specifier of the decode-stage instruction.
REQ-007 w_id_regwrite_1  in  1  the decode-stage instruction writes w_id_rd_5.
REQ-008 w_id_memread_1  in  1  the decode-stage instruction is a load.
REQ-009 w_fwd_a_2 / w_fwd_b_2  out  2 each  registered select for the EX operand A/B 4:1 muxes: 00 register file, 01 MEM-stage ALU result, 10 WB-stage result, 11 retire-stage hold register.
REQ-010 w_stall_1  out  1  load-use stall; the upstream stage holds PC and the ID register while it is high.
REQ-011 w_stall_cnt_16  out  16  stall-cycle counter; present only under FWD_STALL_CNT_EN.

Function
REQ-012 The block SHALL keep four shadow stages, EX, MEM, WB and RET, each holding {valid, rd, regwrite, memread}.
REQ-013 Match(stage, r) SHALL be defined as stage.valid & stage.regwrite & (stage.rd != 0) & (stage.rd == r).
REQ-014 w_stall_1 SHALL be combinational: w_id_valid_1 & EX.valid & EX.memread & EX.rd != 0 & (EX.rd == rs | EX.rd == rt).
REQ-015 When the stall is low, each edge SHALL load EX <= {w_id_valid_1, rd, regwrite, memread} from the ID inputs.
REQ-016 When the stall is high, each edge SHALL load EX with a bubble (valid=0).
REQ-017 Each edge SHALL shift MEM<=EX, WB<=MEM and RET<=WB unconditionally.
REQ-018 When the stall is low, each edge SHALL register w_fwd_a_2 from rs using pre-edge state, first hit wins: Match(EX) ->01, Match(MEM) ->10, Match(WB) ->11, otherwise 00.
REQ-019 w_fwd_b_2 SHALL be computed identically from rt.
REQ-020 Select latency SHALL be one cycle: the selects are valid during the cycle the instruction occupies EX.
REQ-021 When the stall is high, or w_id_valid_1 is 0, the edge SHALL load both selects with 00.
REQ-022 A stall SHALL last exactly one cycle, because EX holds a bubble afterwards.
REQ-023 In the cycle after a stall, the held instruction SHALL match the load in MEM and receive 10.
REQ-024 A register specifier of 0 SHALL never forward or stall.
REQ-025 When rs == rt, both selects SHALL be driven identically.
REQ-026 When several stages match, the youngest (EX) SHALL win.
REQ-027 A non-load match in EX SHALL forward without a stall.

Reset
REQ-028 On an edge with w_rst=1, all stage valid bits SHALL clear and rd/regwrite/memread SHALL clear to 0.
REQ-029 On an edge with w_rst=1, w_fwd_a_2 and w_fwd_b_2 SHALL clear to 00 and w_stall_cnt_16 SHALL clear to 0.
REQ-030 w_stall_1 SHALL be 0 in the cycle after reset, since EX.valid=0.
REQ-031 Reset SHALL take priority over the stall and over the ID inputs, and mid-stall reset SHALL discard all in-flight state.

Configuration
REQ-032 With FWD_STALL_CNT_EN defined, w_stall_cnt_16 SHALL increment by 1 on every edge where w_stall_1=1 and w_rst=0.
REQ-033 The counter SHALL saturate at 16'hFFFF (no wrap).
REQ-034 With FWD_STALL_CNT_EN undefined, the port and counter SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-035 Reset: assert w_rst for 2 cycles with random ID inputs -> fwd_a=fwd_b=00, stall=0, and counter=0 where present.
REQ-036 EX forward: I1 rd=8 regwrite, next I2 rs=8 rt=9 -> in I2's EX cycle fwd_a=01, fwd_b=00, stall never high.
REQ-037 Priority: I1 rd=5, I2 rd=5, I3 rs=5 rt=5 -> I3 gets fwd_a=fwd_b=01 (I2 wins over I1 at 10).
REQ-038 Load-use: load rd=10, next I2 rt=10 -> stall=1 for exactly one cycle, then I2 enters EX with fwd_b=10; with FWD_STALL_CNT_EN the counter reads 1.
REQ-039 Zero register and gap: I1 rd=0 regwrite, then I2 rs=0 -> fwd_a=00; separately I1 rd=7, two NOPs, I4 rs=7 -> fwd_a=11.
REQ-040 Reset mid-stall: raise w_rst in the cycle stall=1 -> next cycle stall=0, selects=00, and no forward to the old load's rd=10 afterwards.
